// File: rtl/transceiver_crc_check.sv
// RX packet integrity monitor: frames SDP/STP..END packets, checks CRC-16 residue and length.
// Error/packet counters exist only when LVDS_RX_CRC_COUNTERS_EN is defined.
module transceiver_crc_check #(
  parameter logic [15:0] CRC_POLY  = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter int          MAX_LEN   = 64,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 i_sys_clk_120,
  input  logic                 i_sys_arst_n,
  input  logic [8:0]           i_data,
  input  logic                 i_status_ack,
  input  logic                 i_cnt_clr,
  output logic                 o_pls_err_dllp,
  output logic                 o_pls_err_tlp,
  output logic                 o_pls_err_frame,
  output logic                 o_status_err,
  output logic [CNT_WIDTH-1:0] o_cnt_dllp_ok,
  output logic [CNT_WIDTH-1:0] o_cnt_dllp_err,
  output logic [CNT_WIDTH-1:0] o_cnt_tlp_ok,
  output logic [CNT_WIDTH-1:0] o_cnt_tlp_err,
  output logic [CNT_WIDTH-1:0] o_cnt_frame_err
);
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DLLP, ST_TLP, ST_DISCARD} state_t;

  state_t           state, state_nxt;
  logic [8:0]       data_p0;
  logic             vld_p0;
  logic [15:0]      crc_p1, crc_nxt;
  logic [LEN_W-1:0] len_p1, len_nxt;
  logic             is_k, is_sdp, is_stp, is_end, in_pkt, is_dllp;
  logic             ev_frame, ev_ok, ev_bad;
  logic [4:0]       cnt_inc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  // Stage p0: input symbol register
  always_ff @(posedge i_sys_clk_120) begin
    data_p0 <= i_data;
  end

  // vld_p0 masks the stale symbol held in data_p0 across a reset release
  always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
    if (!i_sys_arst_n) vld_p0 <= 1'b0;
    else               vld_p0 <= 1'b1;
  end

  assign is_k    = data_p0[8];
  assign is_sdp  = is_k && (data_p0[7:0] == SYM_SDP);
  assign is_stp  = is_k && (data_p0[7:0] == SYM_STP);
  assign is_end  = is_k && (data_p0[7:0] == SYM_END);
  assign in_pkt  = (state == ST_DLLP) || (state == ST_TLP);
  assign is_dllp = (state == ST_DLLP);

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_p1;
    len_nxt   = len_p1;
    ev_frame  = 1'b0;
    ev_ok     = 1'b0;
    ev_bad    = 1'b0;
    if (vld_p0) begin
      if (is_sdp || is_stp) begin
        ev_frame  = in_pkt;
        state_nxt = is_sdp ? ST_DLLP : ST_TLP;
        crc_nxt   = CRC_INIT;
        len_nxt   = '0;
      end else if (in_pkt) begin
        if (is_end) begin
          if (len_p1 < LEN_W'(3)) ev_frame = 1'b1;
          else if (crc_p1 == 16'h0000) ev_ok = 1'b1;
          else ev_bad = 1'b1;
          state_nxt = ST_IDLE;
        end else if (is_k) begin
          ev_frame  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (len_p1 == LEN_W'(MAX_LEN)) begin
          ev_frame  = 1'b1;
          state_nxt = ST_DISCARD;
        end else begin
          crc_nxt = crc_byte(crc_p1, data_p0[7:0]);
          len_nxt = len_p1 + LEN_W'(1);
        end
      end else if (is_end) begin
        ev_frame  = (state == ST_IDLE);
        state_nxt = ST_IDLE;
      end
    end
  end

  assign cnt_inc = {ev_frame, ev_bad & ~is_dllp, ev_ok & ~is_dllp, ev_bad & is_dllp, ev_ok & is_dllp};

  // Stage p1: framing state and registered error outputs
  always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
    if (!i_sys_arst_n) begin
      state           <= ST_IDLE;
      crc_p1          <= CRC_INIT;
      len_p1          <= '0;
      o_pls_err_dllp  <= 1'b0;
      o_pls_err_tlp   <= 1'b0;
      o_pls_err_frame <= 1'b0;
      o_status_err    <= 1'b0;
    end else begin
      state           <= state_nxt;
      crc_p1          <= crc_nxt;
      len_p1          <= len_nxt;
      o_pls_err_dllp  <= cnt_inc[1];
      o_pls_err_tlp   <= cnt_inc[3];
      o_pls_err_frame <= cnt_inc[4];
      o_status_err    <= cnt_inc[1] | cnt_inc[3] | cnt_inc[4] | (o_status_err & ~i_status_ack);
    end
  end

`ifdef LVDS_RX_CRC_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_p1 [5];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
    if (!i_sys_arst_n) begin
      for (int i = 0; i < 5; i++) cnt_p1[i] <= '0;
    end else if (i_cnt_clr) begin
      for (int i = 0; i < 5; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (cnt_inc[i]) cnt_p1[i] <= sat_inc(cnt_p1[i]);
      end
    end
  end

  assign o_cnt_dllp_ok   = cnt_p1[0];
  assign o_cnt_dllp_err  = cnt_p1[1];
  assign o_cnt_tlp_ok    = cnt_p1[2];
  assign o_cnt_tlp_err   = cnt_p1[3];
  assign o_cnt_frame_err = cnt_p1[4];
`else
  logic cnt_unused;
  assign cnt_unused      = ^{i_cnt_clr, cnt_inc};
  assign o_cnt_dllp_ok   = '0;
  assign o_cnt_dllp_err  = '0;
  assign o_cnt_tlp_ok    = '0;
  assign o_cnt_tlp_err   = '0;
  assign o_cnt_frame_err = '0;
`endif

endmodule

// File: doc/transceiver_crc_check.md
# transceiver_crc_check

Receive-side packet integrity monitor for the LVDS transceiver, in the system clock domain. It sits on the 9-bit `{k_en, byte}` stream leaving the RX packet elastic buffer, in parallel with the link layer, and does not modify that stream. It frames DLLP/TLP packets by K-characters, checks each packet's CRC and length, and reports errors as pulses, a sticky status and saturating counters. It is the far-end counterpart of the TX-side CRC corruption injector used for link debug.

## Interface
- `CRC_POLY`, default `DEFAULT_CRC_POLY`: 16-bit CRC polynomial, MSB-first, non-reflected.
- `CRC_INIT`, default `DEFAULT_CRC_INIT`: 16-bit CRC start value, reloaded at every start symbol.
- `MAX_LEN`, default 64: maximum body bytes between the start symbol and END, with CRC included.
- `CNT_WIDTH`, default 16: width of each error/packet counter.
- `i_sys_clk_120` in 1: only clock. All logic is rising-edge.
- `i_sys_arst_n` in 1: asynchronous, active-low reset.
- `i_data` in 9: `[8]` is the k_en flag, `[7:0]` is the byte. One symbol is valid every cycle.
- `i_status_ack` in 1: clears the sticky status.
- `i_cnt_clr` in 1: synchronous clear of all counters.
- `o_pls_err_dllp` / `o_pls_err_tlp` / `o_pls_err_frame` out 1: one-cycle error pulses.
- `o_status_err` out 1: sticky OR of all error pulses.
- `o_cnt_dllp_ok`, `o_cnt_dllp_err`, `o_cnt_tlp_ok`, `o_cnt_tlp_err`, `o_cnt_frame_err` out CNT_WIDTH: saturating counters.

## Operation
- Symbols (valid only when k_en=1):
  - SDP = 0x5C: DLLP start.
  - STP = 0xFB: TLP start.
  - END = 0xFD: packet end.
  - Any other K-code is "unknown K".
- FSM states:
  - IDLE
  - DLLP
  - TLP
  - DISCARD
- Transitions and actions:
  - IDLE + SDP/STP: go to DLLP/TLP. Load CRC with CRC_INIT. Set length to 0.
  - IDLE + END: framing error. Stay in IDLE. Data bytes and unknown K in IDLE are ignored.
  - DLLP/TLP + data byte: update CRC bytewise, MSB first. Increment length.
  - DLLP/TLP + END, length < 3: framing error. Go to IDLE.
  - DLLP/TLP + END, length ≥ 3:
    - CRC residue == 0: ok count for the packet type.
    - Residue != 0: CRC error pulse and count for the packet type.
    - Then go to IDLE.
  - DLLP/TLP + SDP/STP: framing error for the aborted packet. The new packet starts immediately, with CRC and length reloaded.
  - DLLP/TLP + unknown K: framing error. Go to IDLE.
  - DLLP/TLP, length would exceed MAX_LEN: framing error. Go to DISCARD.
  - DISCARD: ignore everything until END (go to IDLE, no further error) or SDP/STP (start a new packet, no further error).
- The transmitter appends the CRC MSB byte first. A correct packet therefore leaves residue 0.
- Counters:
  - Saturate at all-ones. They never wrap.
  - `i_cnt_clr` takes priority over a same-cycle increment; that increment is lost.
- Sticky status:
  - Set by any error pulse.
  - Cleared by `i_status_ack`.
  - If set and ack occur in the same cycle, set wins.

## Timing
- `i_data` is registered on input. A decision on the symbol sampled at edge n is visible on the outputs after edge n+1, i.e. 1 cycle of output latency.
- Error pulses are exactly 1 cycle wide. Back-to-back errors give back-to-back pulses.
- Counters and `o_status_err` update in the same cycle as the corresponding pulse.
- Reset values: FSM is IDLE, all pulses 0, `o_status_err` 0, all counters 0, CRC register CRC_INIT.
- Reset asserted mid-packet aborts the packet silently: no error is reported or counted. After release, the block waits in IDLE for the next start symbol.
- No back-pressure. The block accepts one symbol per cycle without stalling.

## Configuration
- Macro `LVDS_RX_CRC_COUNTERS_EN`.
- Defined: all five counters and `i_cnt_clr` are implemented as above.
- Undefined: no counter registers are implemented, all `o_cnt_*` are constant 0, and `i_cnt_clr` is ignored. Pulses and sticky status are unchanged.

## Test plan
All scenarios use CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
- Good DLLP: SDP, "123456789" (0x31..0x39), 0x29, 0xB1, END. Expect `o_cnt_dllp_ok`=1 and no pulses.
- Corrupt TLP: same body after STP, with CRC byte 0xB0. Expect a single `o_pls_err_tlp` one cycle after END, `o_cnt_tlp_err`=1 and `o_status_err`=1. Hold `i_status_ack` 1 cycle: status returns to 0.
- Framing:
  - Input: END in IDLE; then STP, 2 bytes, END; then SDP, 3 bytes, STP.
  - Expect: 3 framing pulses, `o_cnt_frame_err`=3.
  - The final STP starts a packet that then completes normally.
- Overlong: SDP plus 65 data bytes with MAX_LEN=64. Expect 1 framing pulse at byte 65, and no further error at the trailing END.
- Saturation/clear:
  - With CNT_WIDTH=4, send 20 corrupt DLLPs: counter holds 15.
  - Assert `i_cnt_clr` in the same cycle as a DLLP error: counter reads 0.
  - Ack in the same cycle as a new error: `o_status_err` stays 1.
- Reset mid-packet: assert `i_sys_arst_n`=0 after SDP plus 4 bytes. Expect all outputs 0 immediately. After release, a good DLLP counts as `o_cnt_dllp_ok`=1 and there are no framing errors.
